// File: rtl/io_bus_router.sv
// N-channel IO bus router: decodes a channel from the address, forwards the request
// over a valid/ready handshake and returns read data, timeouts and unmapped errors.
module io_bus_router #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 28,
  parameter int                NUM_CH     = 4,
  parameter int                CH_SEL_W   = 2,
  parameter int                CH_SEL_LSB = 24,
  parameter int                TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     io_valid,
  input  logic                     io_rw,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic [DATA_W-1:0]        io_wr_data,
  output logic [DATA_W-1:0]        io_rd_data,
  output logic                     io_ready,
  output logic                     io_err,
  output logic [7:0]               err_count,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     ch_rw,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wr_data,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
  input  logic [NUM_CH-1:0]        ch_ready
);

  // state | meaning
  // IDLE  | waiting for io_valid; latches and decodes the request
  // WAIT  | channel request outstanding; timer counts down to timeout
  // RESP  | one-cycle io_ready pulse, io_err qualifies it
  // HOLD  | waits for io_valid to drop so a held request cannot re-trigger
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} state_t;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [CH_SEL_W:0]   NUM_CH_W = (CH_SEL_W + 1)'(NUM_CH);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CH_SEL_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]   io_rd_data_q, io_rd_data_d;
  logic                io_ready_q, io_ready_d;
  logic                io_err_q, io_err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [NUM_CH-1:0]   ch_valid_q, ch_valid_d;
  logic                ch_rw_q, ch_rw_d;
  logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]   ch_wr_data_q, ch_wr_data_d;

  logic [CH_SEL_W-1:0] sel_in;
  logic [NUM_CH-1:0]   sel_onehot;
  logic [DATA_W-1:0]   sel_rd_data;
  logic                sel_ready;
  logic [7:0]          err_count_inc;

  assign sel_in        = io_addr[CH_SEL_LSB +: CH_SEL_W];
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_comb begin
    sel_onehot  = '0;
    sel_rd_data = '0;
    sel_ready   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_in == CH_SEL_W'(k)) sel_onehot[k] = 1'b1;
      if (sel_q == CH_SEL_W'(k)) begin
        sel_rd_data = ch_rd_data[k*DATA_W +: DATA_W];
        sel_ready   = ch_ready[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    io_rd_data_d = io_rd_data_q;
    io_ready_d   = 1'b0;
    io_err_d     = 1'b0;
    err_count_d  = err_count_q;
    ch_valid_d   = ch_valid_q;
    ch_rw_d      = ch_rw_q;
    ch_addr_d    = ch_addr_q;
    ch_wr_data_d = ch_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (io_valid) begin
          ch_rw_d      = io_rw;
          ch_addr_d    = io_addr;
          ch_wr_data_d = io_wr_data;
          sel_d        = sel_in;
          if ({1'b0, sel_in} >= NUM_CH_W) begin
            io_ready_d  = 1'b1;
            io_err_d    = 1'b1;
            err_count_d = err_count_inc;
            if (!io_rw) io_rd_data_d = ERR_DATA;
            state_d     = ST_RESP;
          end else begin
            timer_d    = TMR_LOAD;
            ch_valid_d = sel_onehot;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // ready is checked before the terminal count, so a last-cycle ready still succeeds
        if (sel_ready) begin
          ch_valid_d = '0;
          io_ready_d = 1'b1;
          if (!ch_rw_q) io_rd_data_d = sel_rd_data;
          state_d    = ST_RESP;
        end else if (timer_q == '0) begin
          ch_valid_d  = '0;
          io_ready_d  = 1'b1;
          io_err_d    = 1'b1;
          err_count_d = err_count_inc;
          if (!ch_rw_q) io_rd_data_d = ERR_DATA;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: if (!io_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      sel_q        <= '0;
      io_rd_data_q <= '0;
      io_ready_q   <= 1'b0;
      io_err_q     <= 1'b0;
      err_count_q  <= '0;
      ch_valid_q   <= '0;
      ch_rw_q      <= 1'b0;
      ch_addr_q    <= '0;
      ch_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      io_rd_data_q <= io_rd_data_d;
      io_ready_q   <= io_ready_d;
      io_err_q     <= io_err_d;
      err_count_q  <= err_count_d;
      ch_valid_q   <= ch_valid_d;
      ch_rw_q      <= ch_rw_d;
      ch_addr_q    <= ch_addr_d;
      ch_wr_data_q <= ch_wr_data_d;
    end
  end

  assign io_rd_data = io_rd_data_q;
  assign io_ready   = io_ready_q;
  assign io_err     = io_err_q;
  assign err_count  = err_count_q;
  assign ch_valid   = ch_valid_q;
  assign ch_rw      = ch_rw_q;
  assign ch_addr    = ch_addr_q;
  assign ch_wr_data = ch_wr_data_q;

endmodule

// File: tb/tb_io_bus_router.sv
// Bench for io_bus_router: transaction-rule reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_io_bus_router;
  localparam int          DW   = 32;
  localparam int          AW   = 28;
  localparam int          NCH  = 3;
  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              io_valid, io_rw;
  logic [AW-1:0]     io_addr;
  logic [DW-1:0]     io_wr_data, io_rd_data;
  logic              io_ready, io_err;
  logic [7:0]        err_count;
  logic [NCH-1:0]    ch_valid, ch_ready;
  logic              ch_rw;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wr_data;
  logic [NCH*DW-1:0] ch_rd_data;

  int n_pass = 0;
  int n_total = 0;

  io_bus_router #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .CH_SEL_W(2), .CH_SEL_LSB(24),
    .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_valid(io_valid), .io_rw(io_rw), .io_addr(io_addr),
    .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_ready(io_ready), .io_err(io_err),
    .err_count(err_count), .ch_valid(ch_valid), .ch_rw(ch_rw), .ch_addr(ch_addr),
    .ch_wr_data(ch_wr_data), .ch_rd_data(ch_rd_data), .ch_ready(ch_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks a transaction by how long its channel has been waited on,
  // and whether the requester must still drop io_valid before the next acceptance.
  logic           busy = 1'b0, blocked = 1'b0, skip = 1'b0;
  int             waited = 0;
  int             m_sel = 0;
  logic           m_ready = 1'b0, m_err = 1'b0, m_rw = 1'b0;
  logic [31:0]    m_rd = '0, m_wd = '0;
  logic [AW-1:0]  m_addr = '0;
  logic [7:0]     m_cnt = '0;
  logic [NCH-1:0] m_chv = '0;

  task automatic respond(input logic err);
    m_ready = 1'b1;
    m_err   = err;
    busy    = 1'b0;
    m_chv   = '0;
    blocked = 1'b1;
    skip    = 1'b1;
    if (err && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    if (!m_rw) m_rd = err ? ERRD : ch_rd_data[m_sel*DW +: DW];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0; blocked = 1'b0; skip = 1'b0; waited = 0; m_sel = 0;
      m_ready = 1'b0; m_err = 1'b0; m_rw = 1'b0; m_rd = '0; m_wd = '0;
      m_addr = '0; m_cnt = '0; m_chv = '0;
    end else begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (busy) begin
        waited++;
        if (ch_ready[m_sel]) respond(1'b0);
        else if (waited == TO) respond(1'b1);
      end else if (blocked) begin
        if (skip) skip = 1'b0;
        else if (!io_valid) blocked = 1'b0;
      end else if (io_valid) begin
        m_rw   = io_rw;
        m_addr = io_addr;
        m_wd   = io_wr_data;
        m_sel  = int'(io_addr[24 +: 2]);
        if (m_sel >= NCH) respond(1'b1);
        else begin
          busy   = 1'b1;
          waited = 0;
          m_chv  = NCH'(1 << m_sel);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_io_ready", 32'(io_ready), 32'(m_ready));
    chk("m_io_err", 32'(io_err), 32'(m_err));
    chk("m_io_rd_data", io_rd_data, m_rd);
    chk("m_err_count", 32'(err_count), 32'(m_cnt));
    chk("m_ch_valid", 32'(ch_valid), 32'(m_chv));
    chk("m_ch_rw", 32'(ch_rw), 32'(m_rw));
    chk("m_ch_addr", 32'(ch_addr), 32'(m_addr));
    chk("m_ch_wr_data", ch_wr_data, m_wd);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus;
    io_valid = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int nvh, nrdy;

  initial begin
    rst_n = 1'b0; io_valid = 1'b0; io_rw = 1'b0; io_addr = '0; io_wr_data = '0;
    ch_ready = '0; ch_rd_data = '0;
    tick; tick;
    @(negedge clk);
    chk("rst_rd_data", io_rd_data, 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_ch_valid", 32'(ch_valid), 32'h0);
    tick;
    rst_n = 1'b1;
    tick;

    // delayed read on ch1, ready in cycle 4
    ch_rd_data[1*DW +: DW] = 32'h1234_5678;
    io_valid = 1'b1; io_rw = 1'b0; io_addr = 28'h100_0004;
    tick;
    for (int c = 1; c <= 4; c++) begin
      ch_ready = (c == 4) ? 3'b010 : 3'b000;
      @(negedge clk);
      chk("rd_ch_valid", 32'(ch_valid), 32'h2);
      chk("rd_no_ready_yet", 32'(io_ready), 32'h0);
      tick;
    end
    ch_ready = '0;
    @(negedge clk);
    chk("rd_ready", 32'(io_ready), 32'h1);
    chk("rd_err", 32'(io_err), 32'h0);
    chk("rd_data", io_rd_data, 32'h1234_5678);
    tick;
    release_bus;

    // write on ch0, ready in cycle 1
    io_valid = 1'b1; io_rw = 1'b1; io_addr = 28'h000_0010; io_wr_data = 32'hA5;
    tick;
    ch_ready = 3'b001;
    @(negedge clk);
    chk("wr_ch_rw", 32'(ch_rw), 32'h1);
    chk("wr_ch_addr", 32'(ch_addr), 32'h10);
    chk("wr_ch_wr_data", ch_wr_data, 32'hA5);
    tick;
    ch_ready = '0;
    @(negedge clk);
    chk("wr_ready", 32'(io_ready), 32'h1);
    chk("wr_rd_data_kept", io_rd_data, 32'h1234_5678);
    tick;
    release_bus;

    // timeout on ch2
    io_valid = 1'b1; io_rw = 1'b0; io_addr = 28'h200_0000; io_wr_data = '0;
    nvh = 0;
    tick;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (ch_valid == 3'b100) nvh++;
      tick;
    end
    chk("to_valid_cycles", 32'(nvh), 32'd16);
    @(negedge clk);
    chk("to_ready", 32'(io_ready), 32'h1);
    chk("to_err", 32'(io_err), 32'h1);
    chk("to_rd_data", io_rd_data, 32'hDEAD_BEEF);
    chk("to_err_count", 32'(err_count), 32'd1);
    tick;
    io_valid = 1'b0; ch_ready = 3'b100;
    tick;
    ch_ready = '0;
    @(negedge clk);
    chk("late_ready_no_resp", 32'(io_ready), 32'h0);
    chk("late_ready_no_chv", 32'(ch_valid), 32'h0);
    tick;

    // ready in the terminal-count cycle wins
    ch_rd_data[2*DW +: DW] = 32'h0BAD_CAFE;
    io_valid = 1'b1; io_addr = 28'h200_0000;
    tick;
    for (int c = 1; c <= TO; c++) begin
      ch_ready = (c == TO) ? 3'b100 : 3'b000;
      tick;
    end
    ch_ready = '0;
    @(negedge clk);
    chk("edge_ready", 32'(io_ready), 32'h1);
    chk("edge_err", 32'(io_err), 32'h0);
    chk("edge_rd_data", io_rd_data, 32'h0BAD_CAFE);
    chk("edge_err_count", 32'(err_count), 32'd1);
    tick;
    release_bus;

    // unmapped channel 3
    io_valid = 1'b1; io_addr = 28'h300_0000;
    tick;
    @(negedge clk);
    chk("um_ready", 32'(io_ready), 32'h1);
    chk("um_err", 32'(io_err), 32'h1);
    chk("um_ch_valid", 32'(ch_valid), 32'h0);
    chk("um_err_count", 32'(err_count), 32'd2);
    tick;
    io_valid = 1'b0;
    tick;
    for (int i = 0; i < 300; i++) begin
      io_valid = 1'b1;
      tick;
      tick;
      io_valid = 1'b0;
      tick;
    end
    @(negedge clk);
    chk("um_err_count_sat", 32'(err_count), 32'd255);
    tick;

    // held io_valid after the response
    ch_rd_data[0 +: DW] = 32'h5555_AAAA;
    io_valid = 1'b1; io_rw = 1'b0; io_addr = 28'h000_0020;
    nvh = 0; nrdy = 0;
    tick;
    for (int c = 1; c <= 10; c++) begin
      ch_ready = (c == 2) ? 3'b001 : 3'b000;
      if (c == 10) io_valid = 1'b0;
      @(negedge clk);
      if (ch_valid != 0) nvh++;
      if (io_ready) nrdy++;
      tick;
    end
    chk("held_valid_cycles", 32'(nvh), 32'd2);
    chk("held_ready_pulses", 32'(nrdy), 32'd1);
    io_valid = 1'b1; io_addr = 28'h100_0000;
    tick;
    @(negedge clk);
    chk("held_next_accept", 32'(ch_valid), 32'h2);
    ch_ready = 3'b010;
    tick;
    ch_ready = '0;
    @(negedge clk);
    chk("held_next_data", io_rd_data, 32'h1234_5678);
    tick;
    release_bus;

    // reset in cycle 3 of a WAIT
    io_valid = 1'b1; io_rw = 1'b1; io_addr = 28'h100_0040; io_wr_data = 32'h77;
    tick; tick; tick;
    rst_n = 1'b0; io_valid = 1'b0;
    @(negedge clk);
    chk("rw_io_ready", 32'(io_ready), 32'h0);
    chk("rw_io_err", 32'(io_err), 32'h0);
    chk("rw_rd_data", io_rd_data, 32'h0);
    chk("rw_err_count", 32'(err_count), 32'h0);
    chk("rw_ch_valid", 32'(ch_valid), 32'h0);
    chk("rw_ch_rw", 32'(ch_rw), 32'h0);
    chk("rw_ch_addr", 32'(ch_addr), 32'h0);
    chk("rw_ch_wr_data", ch_wr_data, 32'h0);
    tick;
    rst_n = 1'b1;
    tick; tick;
    ch_rd_data[2*DW +: DW] = 32'hCAFE_F00D;
    io_valid = 1'b1; io_rw = 1'b0; io_addr = 28'h200_0008; io_wr_data = '0;
    tick;
    ch_ready = 3'b100;
    tick;
    ch_ready = '0;
    @(negedge clk);
    chk("post_rst_ready", 32'(io_ready), 32'h1);
    chk("post_rst_err", 32'(io_err), 32'h0);
    chk("post_rst_data", io_rd_data, 32'hCAFE_F00D);
    chk("post_rst_err_count", 32'(err_count), 32'h0);
    tick;
    release_bus;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
